// File: rtl/vga_timing_pkg.sv
// 640x480 @ 60 Hz raster constants and the decoded-sync bundle.
// Shared with the game logic so the visible window is defined once.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_VIS_START = 144;
  localparam int DEF_H_VIS_END   = 783;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_VIS_START = 35;
  localparam int DEF_V_VIS_END   = 514;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic bright;
  } vga_sync_t;

  function automatic logic in_range(
    input logic [9:0] x,
    input int         lo,
    input int         hi
  );
    return (int'(x) >= lo) && (int'(x) <= hi);
  endfunction

endpackage

// File: rtl/pix_en_gen.sv
// Pixel-rate divider: counts 0..CLK_DIV-1, registered one-clk pix_en.
// Ports: clk, rst (async high) in; pix_en out.
module pix_en_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div;
  logic [W-1:0] div_next;

  always_comb begin
    div_next = (div == LAST) ? '0 : div + 1'b1;
  end

  // pix_en is registered from div_next so it is high while div==LAST
  // and still reads 0 during reset when CLK_DIV is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_next;
      pix_en <= (div_next == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, sync/bright decode and frame tick.
// Ports: clk, rst in; hSync, vSync, bright, hCount, vCount, pix_en, frame_tick out.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_VIS_START = DEF_H_VIS_START,
  parameter int H_VIS_END   = DEF_H_VIS_END,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_VIS_START = DEF_V_VIS_START,
  parameter int V_VIS_END   = DEF_V_VIS_END
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW   = 10'(H_SYNC);
  localparam logic [9:0] V_SW   = 10'(V_SYNC);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       wrap;
  vga_sync_t  dec;

  pix_en_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_en (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_next = hCount;
    v_next = vCount;
    wrap   = 1'b0;
    if (pix_en) begin
      if (hCount == H_LAST) begin
        h_next = '0;
        if (vCount == V_LAST) begin
          v_next = '0;
          wrap   = 1'b1;
        end else begin
          v_next = vCount + 10'd1;
        end
      end else begin
        h_next = hCount + 10'd1;
      end
    end
  end

  // Decode from the next counts so the registered syncs line up
  // with the counts presented in the same cycle.
  always_comb begin
    dec.hsync  = (h_next >= H_SW);
    dec.vsync  = (v_next >= V_SW);
    dec.bright = in_range(h_next, H_VIS_START, H_VIS_END)
              && in_range(v_next, V_VIS_START, V_VIS_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hCount     <= h_next;
      vCount     <= v_next;
      hSync      <= dec.hsync;
      vSync      <= dec.vsync;
      bright     <= dec.bright;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster.
// Expected outputs come from a closed-form model of edges since reset.
module tb_vga_timing_gen;

  localparam int D   = 3;
  localparam int HT  = 12;
  localparam int HS  = 2;
  localparam int HVS = 4;
  localparam int HVE = 9;
  localparam int VT  = 8;
  localparam int VS  = 2;
  localparam int VVS = 2;
  localparam int VVE = 6;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       pix_en;
  logic       frame_tick;

  typedef struct {
    int hc;
    int vc;
    bit hs;
    bit vs;
    bit br;
    bit pe;
    bit ft;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV     (D),
    .H_TOTAL     (HT),
    .H_SYNC      (HS),
    .H_VIS_START (HVS),
    .H_VIS_END   (HVE),
    .V_TOTAL     (VT),
    .V_SYNC      (VS),
    .V_VIS_START (VVS),
    .V_VIS_END   (VVE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hSync      (hSync),
    .vSync      (vSync),
    .bright     (bright),
    .hCount     (hCount),
    .vCount     (vCount),
    .pix_en     (pix_en),
    .frame_tick (frame_tick)
  );

  // n = rising edges seen since reset was released.
  function automatic exp_t model(input int n);
    exp_t e;
    int   k;
    k    = n / D;
    e.hc = k % HT;
    e.vc = (k / HT) % VT;
    e.hs = (e.hc >= HS);
    e.vs = (e.vc >= VS);
    e.br = (e.hc >= HVS) && (e.hc <= HVE)
        && (e.vc >= VVS) && (e.vc <= VVE);
    e.pe = (n >= 1) && (n % D == D - 1);
    e.ft = (k > 0) && (k % (HT * VT) == 0) && (n % D == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hCount", int'(hCount), e.hc);
      chk("vCount", int'(vCount), e.vc);
      chk("hSync", int'(hSync), int'(e.hs));
      chk("vSync", int'(vSync), int'(e.vs));
      chk("bright", int'(bright), int'(e.br));
      chk("pix_en", int'(pix_en), int'(e.pe));
      chk("frame_tick", int'(frame_tick), int'(e.ft));
    end
  end

  initial begin
    int n;
    int hold;
    n    = 0;
    hold = 4;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst) n = 0;
      else n++;
      if (rst) begin
        if (hold == 0) rst = 1'b0;
        else hold--;
      end else if (cyc == 1500 ||
                   (cyc > 10 && $urandom_range(0, 599) == 0)) begin
        rst  = 1'b1;
        hold = $urandom_range(0, 3);
        n    = 0;
      end
      q.push_back(model(n));
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
